// File: rtl/upower_pkg.sv
// upower_pkg: types and constants shared by the uPower instruction-memory
// loader blocks.
//   INSTR_W          instruction word width in bits
//   BYTES_PER_INSTR  bytes per instruction word on the load stream
//   loader_state_e   state encoding of the instr_mem_loader FSM
package upower_pkg;

    localparam int INSTR_W         = 32;
    localparam int BYTES_PER_INSTR = 4;

    // LD_CHK is only reachable when the checksum feature is compiled in.
    typedef enum logic [2:0] {
        LD_IDLE   = 3'd0,
        LD_HDR_HI = 3'd1,
        LD_HDR_LO = 3'd2,
        LD_DATA   = 3'd3,
        LD_CHK    = 3'd4,
        LD_DONE   = 3'd5
    } loader_state_e;

endpackage

// File: rtl/word_assembler.sv
// word_assembler: packs a byte stream into big-endian instruction words.
// Each accepted byte is shifted into bits [7:0]. When the last byte of a
// word is accepted, the completed word is registered and word_valid pulses
// for one cycle.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clear        drop any partially assembled word (new load starting)
//   byte_en      a byte is being consumed this cycle
//   byte_in      byte value
//   word_last    combinational: this byte_en completes a word
//   word_valid   registered 1-cycle pulse with the completed word
//   word         last completed word (held between pulses)
module word_assembler
    import upower_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               byte_en,
    input  logic [7:0]         byte_in,
    output logic               word_last,
    output logic               word_valid,
    output logic [INSTR_W-1:0] word
);

    logic [INSTR_W-1:0] shift_q, shift_d;
    logic [INSTR_W-1:0] word_q, word_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] shifted;

    assign shifted = {shift_q[INSTR_W-9:0], byte_in};

    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        valid_d   = 1'b0;
        word_last = byte_en && (cnt_q == 2'(BYTES_PER_INSTR - 1));

        if (clear) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (byte_en) begin
            shift_d = shifted;
            cnt_d   = cnt_q + 2'd1;   // wraps to 0 after the last byte
            if (word_last) begin
                valid_d = 1'b1;
                word_d  = shifted;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word_valid = valid_q;
    assign word       = word_q;

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: loads a uPower program into instruction memory from a
// byte stream: 16-bit word count N (MSB first), N big-endian 32-bit words,
// and, when LOADER_CHECKSUM_EN is defined, a trailing XOR checksum byte.
// Words are written to consecutive word addresses starting at 0.
// Optional feature macro: LOADER_CHECKSUM_EN (checksum byte + chk_err).
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           pulse: begin a load (honoured in IDLE or DONE only)
//   byte_valid/_data/_ready  byte stream handshake (transfer on valid&&ready)
//   wr_en/_addr/_data        instruction memory write port
//   busy            load in progress
//   done            load finished, held until next start or reset
//   overflow        header word count exceeded DEPTH (nothing written)
//   chk_err         checksum mismatch (tied 0 without the checksum feature)
module instr_mem_loader
    import upower_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [INSTR_W-1:0] wr_data,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic               chk_err
);

    loader_state_e     state_q, state_d;
    logic [15:0]       n_q, n_d;
    // One bit wider than the address so N == DEPTH ends without wrapping.
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_W:0]   word_cnt_inc;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       hdr_n;
    logic              accept;
    logic              asm_clear;
    logic              asm_byte_en;
    logic              asm_word_last;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        chk_acc_q, chk_acc_d;
    logic              chk_err_q, chk_err_d;
`endif

    // Handshake outputs derive only from the registered state.
    assign byte_ready = (state_q == LD_HDR_HI) || (state_q == LD_HDR_LO) ||
                        (state_q == LD_DATA)   || (state_q == LD_CHK);
    assign busy       = (state_q != LD_IDLE) && (state_q != LD_DONE);
    assign done       = (state_q == LD_DONE);
    assign accept     = byte_valid && byte_ready;
    assign asm_byte_en  = accept && (state_q == LD_DATA);
    assign hdr_n        = {n_q[15:8], byte_data};
    assign word_cnt_inc = word_cnt_q + (ADDR_W+1)'(1);

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_cnt_d = word_cnt_q;
        wr_addr_d  = wr_addr_q;
        overflow_d = overflow_q;
        asm_clear  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        chk_acc_d  = chk_acc_q;
        chk_err_d  = chk_err_q;
`endif

        case (state_q)
            LD_IDLE, LD_DONE: begin
                if (start) begin
                    state_d    = LD_HDR_HI;
                    n_d        = '0;
                    word_cnt_d = '0;
                    overflow_d = 1'b0;
                    asm_clear  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    chk_acc_d  = '0;
                    chk_err_d  = 1'b0;
`endif
                end
            end

            LD_HDR_HI: begin
                if (accept) begin
                    n_d[15:8] = byte_data;
                    state_d   = LD_HDR_LO;
                end
            end

            LD_HDR_LO: begin
                if (accept) begin
                    n_d = hdr_n;
                    if (hdr_n > 16'(DEPTH)) begin
                        overflow_d = 1'b1;
                        state_d    = LD_DONE;
                    end else if (hdr_n == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = LD_CHK;
`else
                        state_d = LD_DONE;
`endif
                    end else begin
                        state_d = LD_DATA;
                    end
                end
            end

            LD_DATA: begin
                if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                    chk_acc_d = chk_acc_q ^ byte_data;
`endif
                    if (asm_word_last) begin
                        // Address is latched alongside the word so both
                        // appear with the wr_en pulse in the next cycle.
                        wr_addr_d  = word_cnt_q[ADDR_W-1:0];
                        word_cnt_d = word_cnt_inc;
                        if (16'(word_cnt_inc) == n_q) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = LD_CHK;
`else
                            state_d = LD_DONE;
`endif
                        end
                    end
                end
            end

`ifdef LOADER_CHECKSUM_EN
            LD_CHK: begin
                if (accept) begin
                    chk_err_d = (byte_data != chk_acc_q);
                    state_d   = LD_DONE;
                end
            end
`endif

            default: state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= LD_IDLE;
            n_q        <= '0;
            word_cnt_q <= '0;
            wr_addr_q  <= '0;
            overflow_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_acc_q  <= '0;
            chk_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            word_cnt_q <= word_cnt_d;
            wr_addr_q  <= wr_addr_d;
            overflow_q <= overflow_d;
`ifdef LOADER_CHECKSUM_EN
            chk_acc_q  <= chk_acc_d;
            chk_err_q  <= chk_err_d;
`endif
        end
    end

    word_assembler u_word_assembler (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (asm_clear),
        .byte_en    (asm_byte_en),
        .byte_in    (byte_data),
        .word_last  (asm_word_last),
        .word_valid (wr_en),
        .word       (wr_data)
    );

    assign wr_addr  = wr_addr_q;
    assign overflow = overflow_q;
`ifdef LOADER_CHECKSUM_EN
    assign chk_err  = chk_err_q;
`else
    assign chk_err  = 1'b0;
`endif

endmodule
